mac_tap_sequencer: RTL and testbench
====================================

Name: mac_tap_sequencer

Overview:
- Controller that runs one N-tap multiply-accumulate pass over the MAC datapath and its two operand FIFOs (signal and coeff).
- Pops both FIFOs in lockstep, clears and enables the accumulator, waits out the datapath pipeline, and flags the finished dot product.
- Sits between the host/start logic and the datapath + FIFO pair. It replaces the free-running load/reset control with a counted, handshaked sequence.

Parameters:
- CNT_W, 8, width of the tap counter and num_taps.
- PIPE_LAT, 2, cycles from an operand pop to the matching accumulator update in the datapath (≥1).
- TIMEOUT, 255, consecutive stall cycles in STREAM before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a new pass; sampled only in IDLE.
- num_taps  in  CNT_W  tap count, latched when start is accepted.
- sig_empty  in  1  signal FIFO empty flag.
- coef_empty  in  1  coeff FIFO empty flag.
- pop_signal  out  1  pop strobe to the signal FIFO / LD_signal.
- pop_coeff  out  1  pop strobe to the coeff FIFO / LD_coeff.
- acc_clr  out  1  one-cycle accumulator clear.
- acc_en  out  1  accumulator update enable; equals a pop delayed by PIPE_LAT.
- result_valid  out  1  one-cycle pulse: datapath result is final.
- busy  out  1  high in every state except IDLE.
- taps_done  out  CNT_W  number of pops issued in the current pass.
- err_timeout  out  1  sticky abort flag; tied 0 without the optional feature.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, delay line flushed. All outputs are 0 after that edge, including taps_done and err_timeout. Applies mid-pass too: the pass is dropped and no result_valid is produced.
- States and transitions:
  - IDLE: start=1 → latch num_taps, clear taps_done → CLEAR.
  - CLEAR: acc_clr=1 for exactly one cycle. Next state is STREAM if num_taps≠0, otherwise DONE.
  - STREAM:
    - pop = !sig_empty && !coef_empty && taps_done<num_taps. Outputs pop_signal=pop_coeff=pop; they are never unequal.
    - Each pop increments taps_done.
    - An empty FIFO stalls the pass: no pop, counter holds.
    - The cycle that issues pop number num_taps transitions → DRAIN.
  - DRAIN: no pops; stay exactly PIPE_LAT cycles → DONE.
  - DONE: result_valid=1 for one cycle → IDLE.
- acc_en is a PIPE_LAT-deep shift of pop. It is independent of state, so in-flight enables complete during DRAIN.
- start while busy=1 is ignored.
- Nominal latency (FIFOs never empty), with start sampled at edge of cycle 0:
  - acc_clr in cycle 1.
  - pops in cycles 2..N+1.
  - acc_en in cycles 2+PIPE_LAT..N+1+PIPE_LAT.
  - result_valid in cycle N+2+PIPE_LAT.
- num_taps=0: result_valid in cycle 2, with the accumulator cleared.
- num_taps=2^CNT_W−1: the counter must not wrap; the comparison uses the full width.
- Back-to-back passes: start may be high in the cycle after DONE; no idle gap is required beyond IDLE itself.

Optional Feature:
- Macro MAC_SEQ_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive STREAM cycles without a pop and resets on any pop.
  - On reaching TIMEOUT: flush the delay line (acc_en forced 0), set err_timeout=1, go to IDLE, no result_valid.
  - err_timeout stays 1 until the next accepted start or reset.
- Undefined: no stall counter; STREAM waits indefinitely; err_timeout is constant 0.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN, DONE);
  - default CNT_W and PIPE_LAT constants, shared with the datapath so the latency stays consistent.
- One sub-module: mac_vld_delay, a parameterised PIPE_LAT-deep 1-bit shift register with synchronous clear, producing acc_en.

Test Plan:
- FIFOs preloaded, num_taps=4, PIPE_LAT=2, start in cycle 0:
  - pops in cycles 2–5, acc_en in cycles 4–7, result_valid in cycle 8 only;
  - taps_done=4;
  - result equals the sum of the 4 products.
- num_taps=3, sig_empty=1 for cycles 3–5 → pops in cycles 2, 6, 7; result_valid in cycle 10; pop_signal==pop_coeff every cycle.
- num_taps=0 → acc_clr in cycle 1, result_valid in cycle 2, zero pops, result=0.
- rst_n=0 in cycle 4 of a 4-tap pass:
  - all outputs 0 from cycle 5, no result_valid;
  - a new start in cycle 6 runs a correct full pass.
- start pulsed while busy, then asserted in the DONE+1 cycle → the first start is ignored and the second pass begins immediately.
- MAC_SEQ_TIMEOUT_EN, TIMEOUT=8, both FIFOs empty after 1 pop → err_timeout=1 after 8 stall cycles, state IDLE, no result_valid, flag cleared on the next start.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC state encoding and default datapath widths/latency
package mac_pkg;

  localparam int unsigned MAC_CNT_W    = 8;
  localparam int unsigned MAC_PIPE_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } mac_state_e;

endpackage

// File: rtl/mac_vld_delay.sv
// rtl/mac_vld_delay.sv - DEPTH-stage 1-bit valid delay line with synchronous clear
module mac_vld_delay
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = MAC_PIPE_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift form stays legal for DEPTH == 1.
  assign sr_d  = (sr_q << 1) | DEPTH'(vld_i);
  assign vld_o = sr_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/mac_tap_sequencer.sv
// rtl/mac_tap_sequencer.sv - counted N-tap MAC pass controller; MAC_SEQ_TIMEOUT_EN adds stall abort
module mac_tap_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned CNT_W    = MAC_CNT_W,
  parameter int unsigned PIPE_LAT = MAC_PIPE_LAT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_taps,
  input  logic             sig_empty,
  input  logic             coef_empty,
  output logic             pop_signal,
  output logic             pop_coeff,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             result_valid,
  output logic             busy,
  output logic [CNT_W-1:0] taps_done,
  output logic             err_timeout
);

  localparam int unsigned DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned STL_W = $clog2(TIMEOUT + 1);

  mac_state_e       state_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] taps_q;
  logic [CNT_W-1:0] taps_d;
  logic [DRN_W-1:0] drn_q;
  logic             pop;
  logic             last_pop;
  logic             abort;

  // Full-width compare: num_taps = all-ones must finish without the counter wrapping.
  assign pop      = (state_q == STREAM) && !sig_empty && !coef_empty && (taps_q < num_q);
  assign taps_d   = taps_q + CNT_W'(1);
  assign last_pop = pop && (taps_d == num_q);

`ifdef MAC_SEQ_TIMEOUT_EN
  logic [STL_W-1:0] stall_q;
  logic             err_q;

  assign abort       = (state_q == STREAM) && !pop && (stall_q == STL_W'(TIMEOUT - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        err_q <= 1'b0;
      end else if (abort) begin
        err_q <= 1'b1;
      end
      if (state_q != STREAM || pop) begin
        stall_q <= '0;
      end else if (!abort) begin
        stall_q <= stall_q + STL_W'(1);
      end
    end
  end
`else
  logic [STL_W-1:0] unused_stall;

  assign unused_stall = '0;
  assign abort        = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      taps_q  <= '0;
      drn_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            num_q   <= num_taps;
            taps_q  <= '0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          drn_q   <= '0;
          state_q <= (num_q != '0) ? STREAM : DONE;
        end
        STREAM: begin
          if (pop) begin
            taps_q <= taps_d;
          end
          if (last_pop) begin
            state_q <= DRAIN;
          end else if (abort) begin
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (drn_q == DRN_W'(PIPE_LAT - 1)) begin
            state_q <= DONE;
          end else begin
            drn_q <= drn_q + DRN_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pop_signal   = pop;
  assign pop_coeff    = pop;
  assign acc_clr      = (state_q == CLEAR);
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign taps_done    = taps_q;

  // Enables already in flight keep flowing through DRAIN; only an abort drops them.
  mac_vld_delay #(
    .DEPTH (PIPE_LAT)
  ) u_vld_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (abort),
    .vld_i (pop),
    .vld_o (acc_en)
  );

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// tb/tb_mac_tap_sequencer.sv - directed self-checking bench for mac_tap_sequencer
module tb_mac_tap_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] num_taps;
  logic       sig_empty;
  logic       coef_empty;
  logic       pop_signal;
  logic       pop_coeff;
  logic       acc_clr;
  logic       acc_en;
  logic       result_valid;
  logic       busy;
  logic [7:0] taps_done;
  logic       err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] pop_m, en_m, clr_m, rv_m, busy_m, err_m, zero_m;
  int          neq_cnt, rv_cnt, rv_first, last_taps;

  int sig_rd, coef_rd, acc;
  int prod_q[$];

  always #5 clk = ~clk;

  mac_tap_sequencer #(
    .CNT_W    (8),
    .PIPE_LAT (2),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_taps     (num_taps),
    .sig_empty    (sig_empty),
    .coef_empty   (coef_empty),
    .pop_signal   (pop_signal),
    .pop_coeff    (pop_coeff),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .result_valid (result_valid),
    .busy         (busy),
    .taps_done    (taps_done),
    .err_timeout  (err_timeout)
  );

  // Datapath model: FIFO word i holds signal i+1 and coeff i+5.
  always @(negedge clk) begin
    if (acc_clr) acc = 0;
    if (acc_en && prod_q.size() > 0) acc += prod_q.pop_front();
    if (pop_signal && pop_coeff) prod_q.push_back((sig_rd + 1) * (coef_rd + 5));
    if (pop_signal) sig_rd++;
    if (pop_coeff) coef_rd++;
    if (!rst_n) prod_q.delete();
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n, input logic [63:0] start_s, input logic [63:0] sig_s,
                     input logic [63:0] coef_s, input int rst_c, input int ncyc);
    pop_m = '0; en_m = '0; clr_m = '0; rv_m = '0; busy_m = '0; err_m = '0; zero_m = '0;
    neq_cnt = 0; rv_cnt = 0; rv_first = -1;
    sig_rd = 0; coef_rd = 0;
    num_taps = 8'(n);
    for (int c = 0; c < ncyc; c++) begin
      start      = (c < 64) ? start_s[c] : 1'b0;
      sig_empty  = (c < 64) ? sig_s[c]   : 1'b0;
      coef_empty = (c < 64) ? coef_s[c]  : 1'b0;
      rst_n      = (c == rst_c) ? 1'b0 : 1'b1;
      #1;
      if (pop_signal !== pop_coeff) neq_cnt++;
      if (result_valid) begin
        rv_cnt++;
        if (rv_first < 0) rv_first = c;
      end
      if (c < 64) begin
        pop_m[c]  = pop_signal;
        en_m[c]   = acc_en;
        clr_m[c]  = acc_clr;
        rv_m[c]   = result_valid;
        busy_m[c] = busy;
        err_m[c]  = err_timeout;
        zero_m[c] = !(pop_signal | pop_coeff | acc_en | acc_clr | result_valid | busy | err_timeout)
                    && (taps_done == 8'd0);
      end
      last_taps = int'(taps_done);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_taps = '0; sig_empty = 1'b0; coef_empty = 1'b0;
    sig_rd = 0; coef_rd = 0; acc = -1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("reset_outputs",
             {56'd0, pop_signal, pop_coeff, acc_clr, acc_en, result_valid, busy, err_timeout, |taps_done},
             64'd0);

    // Nominal 4-tap pass.
    run(4, 64'h1, 64'h0, 64'h0, -1, 12);
    check_eq("n4_pops", pop_m, 64'h3C);
    check_eq("n4_acc_en", en_m, 64'hF0);
    check_eq("n4_result_valid", rv_m, 64'h100);
    check_eq("n4_acc_clr", clr_m, 64'h2);
    check_eq("n4_busy", busy_m, 64'h1FE);
    check_eq("n4_pop_equal", 64'(neq_cnt), 64'd0);
    check_eq("n4_taps_done", 64'(last_taps), 64'd4);
    check_eq("n4_result", 64'(acc), 64'd70);

    // 3 taps with signal FIFO empty in cycles 3..5.
    run(3, 64'h1, 64'h38, 64'h0, -1, 13);
    check_eq("stall_pops", pop_m, 64'hC4);
    check_eq("stall_acc_en", en_m, 64'h310);
    check_eq("stall_result_valid", rv_m, 64'h400);
    check_eq("stall_pop_equal", 64'(neq_cnt), 64'd0);
    check_eq("stall_taps_done", 64'(last_taps), 64'd3);
    check_eq("stall_result", 64'(acc), 64'd38);

    // Zero taps.
    run(0, 64'h1, 64'h0, 64'h0, -1, 5);
    check_eq("n0_acc_clr", clr_m, 64'h2);
    check_eq("n0_result_valid", rv_m, 64'h4);
    check_eq("n0_pops", pop_m, 64'h0);
    check_eq("n0_result", 64'(acc), 64'd0);

    // Reset in cycle 4 of a 4-tap pass, then a fresh pass from cycle 6.
    run(4, 64'h1, 64'h0, 64'h0, 4, 6);
    check_eq("rst_outputs_zero_c5", 64'(zero_m[5]), 64'd1);
    check_eq("rst_no_result", rv_m, 64'h0);
    run(4, 64'h1, 64'h0, 64'h0, -1, 12);
    check_eq("rst_after_pops", pop_m, 64'h3C);
    check_eq("rst_after_result_valid", rv_m, 64'h100);
    check_eq("rst_after_result", 64'(acc), 64'd70);

    // Start while busy is ignored; start in DONE+1 launches immediately.
    run(2, 64'h89, 64'h0, 64'h0, -1, 16);
    check_eq("b2b_acc_clr", clr_m, 64'h102);
    check_eq("b2b_pops", pop_m, 64'h60C);
    check_eq("b2b_result_valid", rv_m, 64'h2040);

    // Full-width tap count must not wrap.
    run(255, 64'h1, 64'h0, 64'h0, -1, 262);
    check_eq("max_rv_cycle", 64'(rv_first), 64'd259);
    check_eq("max_rv_count", 64'(rv_cnt), 64'd1);
    check_eq("max_taps_done", 64'(last_taps), 64'd255);
    check_eq("max_result", 64'(acc), 64'd5690240);

`ifdef MAC_SEQ_TIMEOUT_EN
    // Both FIFOs empty after one pop: abort after 8 stall cycles, restart in cycle 12.
    run(4, 64'h1001, 64'hFF8, 64'hFF8, -1, 24);
    check_eq("to_err_flag", err_m, 64'h1800);
    check_eq("to_busy_c11", 64'(busy_m[11]), 64'd0);
    check_eq("to_result_valid", rv_m, 64'h100000);
    check_eq("to_pops", pop_m, 64'h3C004);
    check_eq("to_acc_en", en_m, 64'hF0010);
`else
    // Without the abort feature a stalled pass waits and the flag never rises.
    run(4, 64'h1, 64'hFFFFFFF8, 64'hFFFFFFF8, -1, 32);
    check_eq("nto_err_flag", err_m, 64'h0);
    check_eq("nto_busy", busy_m[31:1], 31'h7FFFFFFF);
    check_eq("nto_result_valid", rv_m, 64'h0);
    check_eq("nto_taps_done", 64'(last_taps), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
